// File: rtl/cyq_ser_pkg.sv
// Shared types and sizing helpers for the PISO serializer feeding the "011" detector.
// SER_PARITY_EN (optional) appends one even-parity bit to every word.
package cyq_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

  // Serial bits per word, including the optional parity bit.
  function automatic int ser_nbits(input int width);
`ifdef SER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  // Counter width for a counter holding 0..n-1; never narrower than one bit.
  function automatic int ser_cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cyq_piso_serializer_if.sv
// Word-load handshake plus serial output bundle between the serializer and its neighbours.
interface cyq_piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] Din;
  logic             Load;
  logic             Ready;
  logic             X;
  logic             XValid;
  logic             Done;

  // Word source / detector side.
  modport master (
    output Din, Load,
    input  Ready, X, XValid, Done
  );

  // Serializer side.
  modport slave (
    input  Din, Load,
    output Ready, X, XValid, Done
  );
endinterface

// File: rtl/cyq_ser_bit_cnt.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module cyq_ser_bit_cnt #(
  parameter int W = 3
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i)                       cnt_d = ld_val_i;
    else if (dec_i && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/cyq_piso_serializer.sv
// Parallel-in/serial-out stage: one word per Load/Ready handshake, one bit per Clk on X.
// SER_PARITY_EN (optional) sends an even-parity bit after the data bits.
module cyq_piso_serializer
  import cyq_ser_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  cyq_piso_serializer_if.slave  bus
);
  localparam int NBITS = ser_nbits(WIDTH);
  localparam int CW    = ser_cw(NBITS);
  localparam int GW    = ser_cw(GAP_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(NBITS - 1);
  localparam logic [GW-1:0] GAP_INIT = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  ser_state_t       state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [NBITS-1:0] load_val, shifted;
  logic             head;
  logic             cnt_zero, gcnt_zero;
  logic             rdy, accept, last_bit;

  // Parity sits at the tail end of the shift order so it always leaves last.
  always_comb begin
`ifdef SER_PARITY_EN
    if (MSB_FIRST != 0) load_val = {bus.Din, ^bus.Din};
    else                load_val = {^bus.Din, bus.Din};
`else
    load_val = bus.Din;
`endif
  end

  always_comb begin
    if (MSB_FIRST != 0) begin
      head    = shreg_q[NBITS-1];
      shifted = {shreg_q[NBITS-2:0], 1'b0};
    end else begin
      head    = shreg_q[0];
      shifted = {1'b0, shreg_q[NBITS-1:1]};
    end
  end

  assign last_bit = (state_q == SHIFT) && cnt_zero;
  assign rdy      = (state_q == IDLE)
                 || (last_bit && (GAP_CYCLES == 0))
                 || ((state_q == GAP) && gcnt_zero);
  assign accept   = bus.Load && rdy;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = load_val;
        end
      end
      SHIFT: begin
        shreg_d = shifted;
        if (cnt_zero) begin
          if (accept) begin
            shreg_d = load_val;
          end else if (GAP_CYCLES != 0) begin
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gcnt_zero) begin
          if (accept) begin
            state_d = SHIFT;
            shreg_d = load_val;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  cyq_ser_bit_cnt #(.W(CW)) u_cnt (
    .gclk     (Clk),
    .grst_n   (Rst),
    .ld_i     (accept),
    .ld_val_i (CNT_INIT),
    .dec_i    (state_q == SHIFT),
    .zero_o   (cnt_zero)
  );

  cyq_ser_bit_cnt #(.W(GW)) u_gcnt (
    .gclk     (Clk),
    .grst_n   (Rst),
    .ld_i     (last_bit && (GAP_CYCLES != 0)),
    .ld_val_i (GAP_INIT),
    .dec_i    (state_q == GAP),
    .zero_o   (gcnt_zero)
  );

  // Idle/gap cycles drive X low so the detector only ever sees zeros between words.
  assign bus.X      = (state_q == SHIFT) && head;
  assign bus.XValid = (state_q == SHIFT);
  assign bus.Done   = last_bit;
  assign bus.Ready  = rdy;
endmodule

// File: tb/tb_cyq_piso_serializer.sv
// Directed bench: a no-gap MSB-first instance and a GAP_CYCLES=2 LSB-first instance.
module tb_cyq_piso_serializer;
`ifdef SER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic Clk = 1'b0;
  logic Rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 Clk = ~Clk;

  cyq_piso_serializer_if #(.WIDTH(8)) m_if ();
  cyq_piso_serializer_if #(.WIDTH(8)) g_if ();

  cyq_piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(0)) u_main (
    .Clk (Clk), .Rst (Rst), .bus (m_if)
  );
  cyq_piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(2)) u_gap (
    .Clk (Clk), .Rst (Rst), .bus (g_if)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit i of the serial stream for word d; index 8 is the parity bit.
  function automatic logic exp_bit(input logic [7:0] d, input int i, input bit msb);
    if (i >= 8) return ^d;
    return msb ? d[7-i] : d[i];
  endfunction

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic start_main(input logic [7:0] d);
    m_if.Din = d; m_if.Load = 1'b1;
    step();
    m_if.Load = 1'b0;
  endtask

  // Checks one word on the main instance; optionally pokes Load at cycle ign and chains nd.
  task automatic shift_check(input logic [7:0] d, input bit nxt, input logic [7:0] nd, input int ign);
    for (int i = 1; i <= NB; i++) begin
      chk($sformatf("X w%0h c%0d", d, i), m_if.X, exp_bit(d, i-1, 1'b1));
      chk($sformatf("XValid w%0h c%0d", d, i), m_if.XValid, 1);
      chk($sformatf("Done w%0h c%0d", d, i), m_if.Done, (i == NB));
      chk($sformatf("Ready w%0h c%0d", d, i), m_if.Ready, (i == NB));
      m_if.Load = 1'b0;
      if (i == ign) begin m_if.Load = 1'b1; m_if.Din = 8'hFF; end
      if (i == NB && nxt) begin m_if.Load = 1'b1; m_if.Din = nd; end
      step();
    end
  endtask

  task automatic idle_check(input string tag);
    chk({tag, " X"},      m_if.X, 0);
    chk({tag, " XValid"}, m_if.XValid, 0);
    chk({tag, " Done"},   m_if.Done, 0);
    chk({tag, " Ready"},  m_if.Ready, 1);
  endtask

  task automatic gap_word(input logic [7:0] d);
    for (int i = 1; i <= NB; i++) begin
      chk($sformatf("gX w%0h c%0d", d, i), g_if.X, exp_bit(d, i-1, 1'b0));
      chk($sformatf("gXValid w%0h c%0d", d, i), g_if.XValid, 1);
      chk($sformatf("gDone w%0h c%0d", d, i), g_if.Done, (i == NB));
      chk($sformatf("gReady w%0h c%0d", d, i), g_if.Ready, 0);
      step();
    end
  endtask

  task automatic gap_cycle(input string tag, input logic rdy);
    chk({tag, " X"},      g_if.X, 0);
    chk({tag, " XValid"}, g_if.XValid, 0);
    chk({tag, " Done"},   g_if.Done, 0);
    chk({tag, " Ready"},  g_if.Ready, rdy);
  endtask

  initial begin
    Rst = 1'b0;
    m_if.Din = '0; m_if.Load = 1'b0;
    g_if.Din = '0; g_if.Load = 1'b0;
    step(); step();
    idle_check("rst");
    gap_cycle("grst", 1'b1);
    @(negedge Clk); Rst = 1'b1;
    step();
    idle_check("post-rst");

    // Single word 0x60: 0,1,1,0,0,0,0,0
    start_main(8'h60);
    shift_check(8'h60, 1'b0, 8'h00, 0);
    idle_check("after60");

    // Back-to-back A5 then 3C with no bubble
    start_main(8'hA5);
    shift_check(8'hA5, 1'b1, 8'h3C, 0);
    shift_check(8'h3C, 1'b0, 8'h00, 0);
    idle_check("after3C");

    // Load of FF while busy is ignored; Din stays FF afterwards
    start_main(8'h00);
    shift_check(8'h00, 1'b0, 8'h00, 4);
    idle_check("after00");

    // Asynchronous reset during cycle 4 of a word
    start_main(8'hF0);
    step(); step(); step();
    chk("pre-rst XValid", m_if.XValid, 1);
    chk("pre-rst X", m_if.X, exp_bit(8'hF0, 3, 1'b1));
    #2 Rst = 1'b0;
    #1 idle_check("midrst");
    @(negedge Clk); Rst = 1'b1;
    step();
    idle_check("rel");
    start_main(8'h81);
    shift_check(8'h81, 1'b0, 8'h00, 0);
    idle_check("after81");

    // Gap instance, Load held high: second word accepted only in the second gap cycle
    g_if.Din = 8'h5A; g_if.Load = 1'b1;
    step();
    g_if.Din = 8'hB4;
    gap_word(8'h5A);
    gap_cycle("gap1", 1'b0);
    step();
    gap_cycle("gap2", 1'b1);
    step();
    g_if.Load = 1'b0;
    gap_word(8'hB4);
    gap_cycle("gap1b", 1'b0);
    step();
    gap_cycle("gap2b", 1'b1);
    step();
    gap_cycle("gidle", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
